// File: rtl/usb_pkg.sv
// usb_pkg: shared widths, the stored word format and the byte-mask helper
// used by the USB receive FIFO and its interface.
`timescale 1ns/1ps
package usb_pkg;

    localparam int USB_DATA_W = 16;
    localparam int USB_BE_W   = 2;

    // One FIFO entry: byte enables above the 16-bit data word.
    typedef struct packed {
        logic [1:0]  be;
        logic [15:0] data;
    } usb_word_t;

    // Zero every byte whose enable is low so consumers never see stale bus bytes.
    function automatic usb_word_t usb_mask_word(input usb_word_t w);
        usb_word_t m;
        m.be         = w.be;
        m.data[7:0]  = w.be[0] ? w.data[7:0]  : 8'h00;
        m.data[15:8] = w.be[1] ? w.data[15:8] : 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/usb_rx_fifo_if.sv
// usb_rx_fifo_if: bundles the capture side (in_*, rx_allow), the valid/ready
// output stream (out_*) and the status outputs (level, overflow, word_count).
// master = controller/consumer side, slave = the FIFO.
`timescale 1ns/1ps
interface usb_rx_fifo_if
    import usb_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic                  in_valid;
    logic [USB_DATA_W-1:0] in_data;
    logic [USB_BE_W-1:0]   in_be;
    logic                  rx_allow;

    logic                  out_valid;
    logic                  out_ready;
    logic [USB_DATA_W-1:0] out_data;
    logic [USB_BE_W-1:0]   out_be;

    logic [ADDR_W:0]       level;
    logic                  overflow;
    logic [15:0]           word_count;

    modport master (
        output in_valid,
        output in_data,
        output in_be,
        input  rx_allow,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_be,
        input  level,
        input  overflow,
        input  word_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_be,
        output rx_allow,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_be,
        output level,
        output overflow,
        output word_count
    );

endinterface

// File: rtl/usb_fifo_mem.sv
// usb_fifo_mem: DEPTH x 18 entry storage, one write port, one registered read
// port. Ports: CLK, RST, i_wr_en/i_wr_addr/i_wr_word, i_rd_en/i_rd_addr, o_rd_word.
`timescale 1ns/1ps
module usb_fifo_mem
    import usb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  usb_word_t         i_wr_word,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output usb_word_t         o_rd_word
);

    usb_word_t r_mem [DEPTH];
    usb_word_t r_rd_word;

    // Array contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_word;
        end
    end

    // The read register doubles as the FIFO output stage: it only changes
    // when a new head is loaded, so it holds while stalled or empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_word <= '0;
        end else if (i_rd_en) begin
            r_rd_word <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_word = r_rd_word;

endmodule

// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: receive buffer behind the FT-series USB FIFO bus controller.
// Ports: CLK, RST (async, active high), bus (usb_rx_fifo_if.slave).
`timescale 1ns/1ps
module usb_rx_fifo
    import usb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int BURST  = 4,
    parameter int ADDR_W = 4
) (
    input  logic          CLK,
    input  logic          RST,
    usb_rx_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_BURST = (ADDR_W+1)'(BURST);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_out_valid;
    logic              r_overflow;
    logic              r_rx_allow;
    logic [15:0]       r_word_count;

    logic              w_word_ok;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_load;
    logic [ADDR_W:0]   w_backlog;
    logic [ADDR_W:0]   w_level_next;
    logic [ADDR_W:0]   w_free;
    usb_word_t         w_in_word;
    usb_word_t         w_wr_word;
    usb_word_t         w_rd_word;

    // Full/drop decisions use the registered level, so a same-cycle pop
    // never makes room for a push.
    assign w_word_ok = bus.in_valid & (bus.in_be != 2'b00);
    assign w_full    = (r_level == LP_DEPTH);
    assign w_push    = w_word_ok & ~w_full;
    assign w_drop    = w_word_ok & w_full;
    assign w_pop     = r_out_valid & bus.out_ready;

    // Entries in memory not yet moved into the output register.
    assign w_backlog = r_level - {{ADDR_W{1'b0}}, r_out_valid};
    // Refill the output register whenever it is empty or being consumed.
    assign w_load    = (w_backlog != '0) & (~r_out_valid | w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push & ~w_pop) begin
            w_level_next = r_level + (ADDR_W+1)'(1);
        end else if (~w_push & w_pop) begin
            w_level_next = r_level - (ADDR_W+1)'(1);
        end
    end

    assign w_free = LP_DEPTH - w_level_next;

    always_comb begin
        w_in_word      = '0;
        w_in_word.be   = bus.in_be;
        w_in_word.data = bus.in_data;
        w_wr_word      = usb_mask_word(w_in_word);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_rx_allow   <= 1'b1;
            r_word_count <= '0;
        end else begin
            r_level    <= w_level_next;
            r_rx_allow <= (w_free >= LP_BURST);
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
                r_word_count <= r_word_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // rd_ptr tracks the next entry to fetch into the output stage.
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    usb_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK       (CLK),
        .RST       (RST),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_word (w_wr_word),
        .i_rd_en   (w_load),
        .i_rd_addr (r_rd_ptr),
        .o_rd_word (w_rd_word)
    );

    assign bus.rx_allow   = r_rx_allow;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = w_rd_word.data;
    assign bus.out_be     = w_rd_word.be;
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_usb_rx_fifo.sv
// tb_usb_rx_fifo: directed self-checking bench for usb_rx_fifo.
// Inputs change on the falling edge; outputs are checked there too.
`timescale 1ns/1ps
module tb_usb_rx_fifo;
    import usb_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;

    usb_rx_fifo_if bus ();

    usb_rx_fifo dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int p;
        int q;
        int k;
        logic [15:0] d;

        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_be     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_allow", bus.rx_allow, 1);
        chk("rst_wc", bus.word_count, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_be", bus.out_be, 0);
        RST = 1'b0;
        tick();

        // 1: single word, one cycle of latency
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hA5A5;
        bus.in_be    = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_lat_valid", bus.out_valid, 0);
        chk("t1_level", bus.level, 1);
        chk("t1_wc", bus.word_count, 1);
        tick();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 16'hA5A5);
        chk("t1_be", bus.out_be, 2'b11);
        tick();
        chk("t1_stall_data", bus.out_data, 16'hA5A5);
        chk("t1_stall_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_pop_valid", bus.out_valid, 0);
        chk("t1_pop_level", bus.level, 0);
        chk("t1_hold_data", bus.out_data, 16'hA5A5);

        // 2: byte masking and BE=00 discard
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_be    = 2'b01;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t2_lo_data", bus.out_data, 16'h0034);
        chk("t2_lo_be", bus.out_be, 2'b01);
        chk("t2_wc", bus.word_count, 2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        bus.in_be    = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        chk("t2_be0_wc", bus.word_count, 2);
        chk("t2_be0_level", bus.level, 1);
        chk("t2_be0_ovf", bus.overflow, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_be0_empty", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5678;
        bus.in_be    = 2'b10;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t2_hi_data", bus.out_data, 16'h5600);
        chk("t2_hi_be", bus.out_be, 2'b10);
        chk("t2_hi_wc", bus.word_count, 3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_empty", bus.level, 0);

        // 3: fill to DEPTH, rx_allow falls at 13, 17th word dropped
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hC000 + 16'(i);
            bus.in_be    = 2'b11;
            tick();
            chk("t3_level", bus.level, i + 1);
            chk("t3_allow", bus.rx_allow, (i + 1 <= 12) ? 1 : 0);
        end
        bus.in_data = 16'hDEAD;
        tick();
        bus.in_valid = 1'b0;
        chk("t3_full_level", bus.level, 16);
        chk("t3_ovf", bus.overflow, 1);
        chk("t3_wc", bus.word_count, 19);
        chk("t3_head", bus.out_data, 16'hC000);

        // 4: push+pop while full, then drain in order
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        bus.in_be     = 2'b11;
        bus.out_ready = 1'b1;
        chk("t4_word0", bus.out_data, 16'hC000);
        tick();
        bus.in_valid = 1'b0;
        chk("t4_level", bus.level, 15);
        chk("t4_ovf", bus.overflow, 1);
        chk("t4_wc", bus.word_count, 19);
        for (int i = 1; i < 16; i++) begin
            chk("t4_drain_valid", bus.out_valid, 1);
            chk("t4_drain_data", bus.out_data, 16'hC000 + 16'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t4_end_valid", bus.out_valid, 0);
        chk("t4_end_level", bus.level, 0);
        chk("t4_end_allow", bus.rx_allow, 1);
        chk("t4_ovf_sticky", bus.overflow, 1);

        // 6: asynchronous reset with 7 entries stored
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hD000 + 16'(i);
            bus.in_be    = 2'b11;
            tick();
        end
        chk("t6_pre_level", bus.level, 7);
        bus.in_data = 16'h1111;
        RST = 1'b1;
        #1;
        chk("t6_async_valid", bus.out_valid, 0);
        chk("t6_async_level", bus.level, 0);
        chk("t6_async_ovf", bus.overflow, 0);
        chk("t6_async_wc", bus.word_count, 0);
        chk("t6_async_allow", bus.rx_allow, 1);
        chk("t6_async_data", bus.out_data, 0);
        @(negedge CLK);
        chk("t6_rst_ignore", bus.level, 0);
        chk("t6_rst_wc", bus.word_count, 0);
        RST          = 1'b0;
        bus.in_data  = 16'h7E57;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_post_valid", bus.out_valid, 1);
        chk("t6_post_data", bus.out_data, 16'h7E57);
        chk("t6_post_level", bus.level, 1);

        // 5: 40 words streamed through a wrapping pointer
        RST = 1'b1;
        tick();
        RST = 1'b0;
        p = 0;
        q = 0;
        k = 0;
        while (q < 40 && k < 200) begin
            bus.in_valid  = (k % 2 == 0) && (p < 40);
            d             = 16'h5000 + 16'(p);
            bus.in_data   = d;
            bus.in_be     = 2'b11;
            bus.out_ready = k[0];
            if (bus.out_valid && bus.out_ready) begin
                chk("t5_order", bus.out_data, 16'h5000 + 16'(q));
                q++;
            end
            chk("t5_level_le2", (bus.level <= 2) ? 1 : 0, 1);
            tick();
            if (bus.in_valid) p++;
            k++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_popped", q, 40);
        chk("t5_wc", bus.word_count, 40);
        chk("t5_ovf", bus.overflow, 0);
        tick();
        chk("t5_end_valid", bus.out_valid, 0);
        chk("t5_end_level", bus.level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
